// File: rtl/fpu_dp_divider.sv
// fpu_dp_divider: sequential binary64 divider, radix-2 restoring, one quotient bit per clock.
// Define FPU_DIV_ROUND_NEAREST_EN for round-to-nearest-even (55 iterations); default truncates.
module fpu_dp_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow,
  output logic             div_by_zero
);

`ifdef FPU_DIV_ROUND_NEAREST_EN
  localparam int N = 55;
`else
  localparam int N = 54;
`endif

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

  state_t              state, state_nx;
  logic                sign;
  logic [10:0]         ea, eb;
  logic [52:0]         mb;
  logic [53:0]         rem;
  logic [N-1:0]        q;
  logic [5:0]          cnt;

  logic                ge;
  logic [52:0]         rem_sub;
  logic                hi;
  logic [51:0]         mant;
  logic signed [12:0]  texp;
  logic                ovf, unf;
`ifdef FPU_DIV_ROUND_NEAREST_EN
  logic                guard, sticky;
  logic [52:0]         mant_rnd;
`endif

  assign busy = (state != IDLE);

  // DIVIDE holds one extra cycle at cnt == N so done lands on edge N+2.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = DIVIDE;
      DIVIDE:  if (cnt == 6'(N)) state_nx = NORM;
      NORM:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ge      = (rem >= {1'b0, mb});
    rem_sub = ge ? 53'(rem - {1'b0, mb}) : rem[52:0];
  end

  always_comb begin
    hi   = q[N-1];
    mant = hi ? q[N-2 -: 52] : q[N-3 -: 52];
    texp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (hi ? 13'sd1023 : 13'sd1022);
`ifdef FPU_DIV_ROUND_NEAREST_EN
    // when the integer bit is set, q[0] sits below the guard and joins the sticky
    guard    = hi ? q[1] : q[0];
    sticky   = (hi & q[0]) | (|rem);
    mant_rnd = {1'b0, mant} + 53'(guard & (sticky | mant[0]));
    mant     = mant_rnd[51:0];
    texp     = texp + $signed({12'd0, mant_rnd[52]});
`endif
    ovf = (texp >= 13'sd2047);
    unf = (texp <= 13'sd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sign        <= 1'b0;
      ea          <= '0;
      eb          <= '0;
      mb          <= '0;
      rem         <= '0;
      q           <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign <= A[WIDTH-1] ^ B[WIDTH-1];
            ea   <= A[62:52];
            eb   <= B[62:52];
            mb   <= {1'b1, B[51:0]};
            rem  <= {2'b01, A[51:0]};
            q    <= '0;
            cnt  <= '0;
          end
        end
        DIVIDE: begin
          if (cnt != 6'(N)) begin
            rem <= {rem_sub, 1'b0};
            q   <= {q[N-2:0], ge};
            cnt <= cnt + 6'd1;
          end
        end
        NORM: begin
          done        <= 1'b1;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          div_by_zero <= 1'b0;
          if (eb == '0) begin
            result      <= {sign, 11'h7FF, 52'd0};
            div_by_zero <= 1'b1;
          end else if (ea == '0) begin
            result <= {sign, 63'd0};
          end else if (ovf) begin
            result   <= {sign, 11'h7FF, 52'd0};
            overflow <= 1'b1;
          end else if (unf) begin
            result    <= {sign, 63'd0};
            underflow <= 1'b1;
          end else begin
            result <= {sign, texp[10:0], mant};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_dp_divider.sv
// tb_fpu_dp_divider: randomized and directed checks of fpu_dp_divider against a long-division model.
module tb_fpu_dp_divider;

`ifdef FPU_DIV_ROUND_NEAREST_EN
  localparam int LAT = 57;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 56;
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] a_in, b_in, result;
  logic        busy, done, overflow, underflow, div_by_zero;
  int          total = 0;
  int          bad = 0;

  fpu_dp_divider #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // returns {overflow, underflow, div_by_zero, result}
  function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b);
    logic         s, g, st;
    int           ea, eb, texp;
    logic [112:0] num, den, qq, rr;
    logic [51:0]  man;
    logic [52:0]  mr;
    s   = a[63] ^ b[63];
    ea  = int'(a[62:52]);
    eb  = int'(b[62:52]);
    num = {1'b1, a[51:0], 60'd0};
    den = {60'd0, 1'b1, b[51:0]};
    qq  = num / den;
    rr  = num % den;
    if (qq[60]) begin
      texp = ea - eb + 1023;
      man  = qq[59:8];
      g    = qq[7];
      st   = (|qq[6:0]) || (rr != 0);
    end else begin
      texp = ea - eb + 1022;
      man  = qq[58:7];
      g    = qq[6];
      st   = (|qq[5:0]) || (rr != 0);
    end
    if (RND && g && (st || man[0])) begin
      mr  = {1'b0, man} + 53'd1;
      man = mr[51:0];
      if (mr[52]) texp++;
    end
    if (eb == 0)         return {3'b001, s, 11'h7FF, 52'd0};
    else if (ea == 0)    return {3'b000, s, 63'd0};
    else if (texp >= 2047) return {3'b100, s, 11'h7FF, 52'd0};
    else if (texp <= 0)  return {3'b010, s, 63'd0};
    else                 return {3'b000, s, 11'(texp), man};
  endfunction

  task automatic launch(input logic [63:0] a, input logic [63:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [63:0] a, input logic [63:0] b);
    logic [66:0] m;
    m = model(a, b);
    check({tag, "_res"}, result, m[63:0]);
    check({tag, "_flags"}, 64'({overflow, underflow, div_by_zero}), 64'(m[66:64]));
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b);
    int lat;
    launch(a, b);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check_result(tag, a, b);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  logic [63:0] da [6] = '{64'h4018000000000000, 64'h3FF0000000000000, 64'h7FE0000000000000,
                          64'h0010000000000000, 64'hBFF0000000000000, 64'h0000000000000000};
  logic [63:0] db [6] = '{64'h4000000000000000, 64'h4024000000000000, 64'h3FE0000000000000,
                          64'h4000000000000000, 64'h0000000000000000, 64'h4000000000000000};
  logic [63:0] dr [6];
  logic [2:0]  df [6] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000};

  initial begin
    int          lat, ndone;
    logic [63:0] a, b;
    dr = '{64'h4008000000000000, 64'h3FB9999999999999, 64'h7FF0000000000000,
           64'h0000000000000000, 64'hFFF0000000000000, 64'h0000000000000000};
    if (RND) dr[1] = 64'h3FB999999999999A;

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", result, 64'd0);
    check("rst_ctrl", 64'({busy, done, overflow, underflow, div_by_zero}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("dir%0d", i), da[i], db[i]);
      check($sformatf("dir%0d_const", i), result, dr[i]);
      check($sformatf("dir%0d_cflags", i), 64'({overflow, underflow, div_by_zero}), 64'(df[i]));
    end

    for (int i = 0; i < 60; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 4 != 0) begin
        a[62:52] = 11'($urandom_range(700, 1350));
        b[62:52] = 11'($urandom_range(700, 1350));
      end
      run_op($sformatf("rnd%0d", i), a, b);
    end

    // start during DIVIDE is ignored
    launch(64'h4018000000000000, 64'h4000000000000000);
    repeat (10) begin @(posedge clk); #1; end
    a_in = 64'h3FF0000000000000; b_in = 64'h4024000000000000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", 64'(lat + 11), 64'(LAT));
    check_result("ign", 64'h4018000000000000, 64'h4000000000000000);
    @(posedge clk); #1;
    check("ign_no_second", 64'(busy), 64'd0);

    // rst mid-operation
    launch(64'h3FF0000000000000, 64'h4024000000000000);
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_result", result, 64'd0);
    check("midrst_ctrl", 64'({busy, done, overflow, underflow, div_by_zero}), 64'd0);
    ndone = 0;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);

    run_op("restart", 64'hC01C000000000000, 64'h4008000000000000);

    // back-to-back start in the done cycle
    launch(64'h4018000000000000, 64'h3FF8000000000000);
    wait_done(lat);
    check("b2b1_lat", 64'(lat), 64'(LAT));
    check_result("b2b1", 64'h4018000000000000, 64'h3FF8000000000000);
    launch(64'h3FF0000000000000, 64'h4008000000000000);
    wait_done(lat);
    check("b2b2_lat", 64'(lat), 64'(LAT));
    check_result("b2b2", 64'h3FF0000000000000, 64'h4008000000000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_dp_divider.md
# fpu_dp_divider

Sequential IEEE-754 double-precision divider computing A / B by radix-2 restoring division, one quotient bit per clock. It is the inverse-operation companion of the combinational double-precision multiplier in the FPU datapath and shares its number handling: subnormals flushed, NaN/Inf not special-cased, overflow saturates to signed infinity, underflow flushes to signed zero. Operands are accepted with a start/done handshake, and the result is held until the next completion.

## Interface
- WIDTH, 64, operand/result width; only 64 is supported.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operand-capture request; honoured only when idle.
- A  input  WIDTH  dividend, IEEE-754 binary64.
- B  input  WIDTH  divisor, IEEE-754 binary64.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  single-cycle pulse; result and flags valid from this cycle.
- result  output  WIDTH  quotient; held until the next done.
- overflow  output  1  result saturated to signed infinity.
- underflow  output  1  result flushed to signed zero.
- div_by_zero  output  1  divisor exponent was 0.

## Operation
- States: IDLE, DIVIDE, NORM.
- IDLE: when start=1, capture sign = A[63]^B[63], EA, EB, Ma = {1,A[51:0]} and Mb = {1,B[51:0]} (53 bits). Load rem = Ma and clear the quotient register and iteration counter. Go to DIVIDE.
- DIVIDE: each cycle, if rem >= Mb then rem = rem - Mb and shift 1 into q; otherwise shift 0. Then rem <<= 1.
  - Run N iterations: N = 54 by default, 55 with rounding enabled.
  - rem is 54 bits wide.
  - After the last iteration go to NORM.
- NORM:
  - If q[N-1]=1, mantissa = the 52 bits below q[N-1] and Texp = EA - EB + 1023.
  - Otherwise mantissa = the 52 bits below q[N-2] and Texp = EA - EB + 1022.
  - Texp is 13-bit signed.
  - Register the outputs, pulse done, return to IDLE.
- Output priority, first match wins:
  1. EB == 0: result = {sign, 11'h7FF, 52'd0}, div_by_zero=1, overflow=0, underflow=0.
  2. EA == 0: result = {sign, 63'd0}, all flags 0.
  3. Texp >= 2047: result = {sign, 11'h7FF, 52'd0}, overflow=1.
  4. Texp <= 0: result = {sign, 63'd0}, underflow=1.
  5. Otherwise: result = {sign, Texp[10:0], mantissa}.
- Flags not set by the matching case are 0 at done.
- Exponent 2047 inputs are treated as ordinary finite encodings.
- Special cases still run the full iteration count, so latency is fixed.

## Timing
- Reset: IDLE; busy=0, done=0, result=0, overflow=0, underflow=0, div_by_zero=0; internal registers cleared.
- Edge 0 samples start in IDLE. busy=1 from edge 1 until the NORM edge. result, flags and done=1 appear after edge N+2 (edge 56, or 57 with rounding). busy=0 in the done cycle.
- done is high for exactly one cycle. result and flags are stable until the next done or rst.
- start while busy or in the done cycle's IDLE: a back-to-back start in the done cycle is accepted (the FSM is IDLE then). start during DIVIDE/NORM is ignored and not queued.
- A and B are sampled only on the accepting edge. Later changes have no effect.
- rst mid-operation: next state IDLE, all outputs zero, no done for the aborted operation.

## Configuration
- FPU_DIV_ROUND_NEAREST_EN defined:
  - N = 55 (one guard bit); sticky = (rem != 0) after the last iteration.
  - Round to nearest-even on {mantissa, guard, sticky}.
  - A mantissa carry-out increments Texp before the overflow check.
  - Latency 57.
- Undefined: truncation, N = 54, latency 56.

## Test plan
- 0x4018000000000000 / 0x4000000000000000 (6.0/2.0) -> result 0x4008000000000000, flags 0, done exactly 56 (57 with macro) edges after start.
- 0x3FF0000000000000 / 0x4024000000000000 (1.0/10.0) -> 0x3FB9999999999999 without macro, 0x3FB999999999999A with FPU_DIV_ROUND_NEAREST_EN.
- 0x7FE0000000000000 / 0x3FE0000000000000 -> 0x7FF0000000000000, overflow=1. 0x0010000000000000 / 0x4000000000000000 -> 0x0000000000000000, underflow=1.
- 0xBFF0000000000000 / 0x0000000000000000 -> 0xFFF0000000000000, div_by_zero=1. 0x0000000000000000 / 0x4000000000000000 -> 0x0000000000000000, flags 0.
- Assert start again at cycle 10 of an operation -> ignored, and the first result is unchanged.
- Assert rst at cycle 20 -> outputs 0 next edge, no done.
- Restart from IDLE -> correct fresh result.
- Start in the done cycle -> accepted, second done 56 edges later.
